// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC feeder (state encoding, count width).
package mac_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [2:0] {
    CLEAR,
    FEED,
    DRAIN,
    CAPTURE,
    OUT
  } mac_feeder_state_t;

  function automatic int cnt_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/mac_feeder_if.sv
// Operand-in / result-out stream bundle for mac_feeder.
// MAC_FEEDER_LAST_EN adds s_last on the input side and m_len on the output side.
interface mac_feeder_if
  import mac_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int VEC_LEN = 16
);

  localparam int CNT_W = cnt_w(VEC_LEN);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_a;
  logic [DATA_W-1:0] s_b;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_sum;
`ifdef MAC_FEEDER_LAST_EN
  logic              s_last;
  logic [CNT_W-1:0]  m_len;

  modport slave (
    input  s_valid, s_a, s_b, s_last, m_ready,
    output s_ready, m_valid, m_sum, m_len
  );

  modport master (
    output s_valid, s_a, s_b, s_last, m_ready,
    input  s_ready, m_valid, m_sum, m_len
  );
`else
  modport slave (
    input  s_valid, s_a, s_b, m_ready,
    output s_ready, m_valid, m_sum
  );

  modport master (
    output s_valid, s_a, s_b, m_ready,
    input  s_ready, m_valid, m_sum
  );
`endif

endinterface

// File: rtl/mac_unit.sv
// Free-running multiply-accumulator: adds in_a*in_b every cycle, modulo 2^data_size.
module mac_unit #(
  parameter int data_size = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [data_size-1:0] in_a,
  input  logic [data_size-1:0] in_b,
  output logic [data_size-1:0] out_sum
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_sum <= '0;
    end else begin
      out_sum <= out_sum + in_a * in_b;
    end
  end

endmodule

// File: rtl/mac_feeder.sv
// Sequences operand pairs into a mac_unit, one dot product per VEC_LEN pairs.
// Optional: MAC_FEEDER_LAST_EN enables early termination via s_last and reports m_len.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int VEC_LEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  mac_feeder_if.slave       s,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_clr,
  input  logic [DATA_W-1:0] mac_sum,
  output logic              busy
);

  localparam int CNT_W = cnt_w(VEC_LEN);

  mac_feeder_state_t state_reg, state_next;
  logic [CNT_W-1:0]  count_reg;
  logic [DATA_W-1:0] mac_a_reg, mac_b_reg, m_sum_reg;
  logic              m_valid_reg;
  logic              s_ready_int;
  logic              hs;
  logic              last_hs;

  assign hs = s.s_valid && s_ready_int;

`ifdef MAC_FEEDER_LAST_EN
  logic [CNT_W-1:0] m_len_reg;
  assign last_hs  = hs && ((count_reg == CNT_W'(VEC_LEN - 1)) || s.s_last);
  assign s.m_len  = m_len_reg;
`else
  assign last_hs  = hs && (count_reg == CNT_W'(VEC_LEN - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= CLEAR;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CLEAR:   state_next = FEED;
      FEED:    if (last_hs) state_next = DRAIN;
      DRAIN:   state_next = CAPTURE;
      CAPTURE: state_next = OUT;
      OUT:     if (s.m_ready) state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  // mac_clr follows reset combinationally so the MAC clears in the same edge as this block.
  always_comb begin
    s_ready_int = (state_reg == FEED);
    mac_clr     = reset || (state_reg == CLEAR);
    busy        = (state_reg != FEED) || (count_reg != '0);
  end

  // Operands default to zero every cycle: the MAC has no enable, so idle cycles must add 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg   <= '0;
      mac_a_reg   <= '0;
      mac_b_reg   <= '0;
      m_sum_reg   <= '0;
      m_valid_reg <= 1'b0;
`ifdef MAC_FEEDER_LAST_EN
      m_len_reg   <= '0;
`endif
    end else begin
      mac_a_reg <= '0;
      mac_b_reg <= '0;
      case (state_reg)
        CLEAR: count_reg <= '0;
        FEED: begin
          if (hs) begin
            mac_a_reg <= s.s_a;
            mac_b_reg <= s.s_b;
            count_reg <= count_reg + 1'b1;
          end
        end
        CAPTURE: begin
          m_sum_reg   <= mac_sum;
          m_valid_reg <= 1'b1;
`ifdef MAC_FEEDER_LAST_EN
          m_len_reg   <= count_reg;
`endif
        end
        OUT: if (s.m_ready) m_valid_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign s.s_ready = s_ready_int;
  assign s.m_valid = m_valid_reg;
  assign s.m_sum   = m_sum_reg;
  assign mac_a     = mac_a_reg;
  assign mac_b     = mac_b_reg;

endmodule

// File: tb/tb_mac_feeder.sv
// Directed self-checking bench: mac_feeder paired with mac_unit, VEC_LEN=4 and VEC_LEN=1 instances.
module tb_mac_feeder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mac_feeder_if #(.DATA_W(8), .VEC_LEN(4)) b4 ();
  mac_feeder_if #(.DATA_W(8), .VEC_LEN(1)) b1 ();

  logic [7:0] a4, bb4, sum4, a1, bb1, sum1;
  logic       clr4, clr1, busy4, busy1;

  mac_feeder #(.DATA_W(8), .VEC_LEN(4)) dut4 (
    .clk(clk), .reset(reset), .s(b4.slave), .mac_a(a4), .mac_b(bb4),
    .mac_clr(clr4), .mac_sum(sum4), .busy(busy4)
  );
  mac_unit #(.data_size(8)) mac4 (
    .clk(clk), .reset(clr4), .in_a(a4), .in_b(bb4), .out_sum(sum4)
  );

  mac_feeder #(.DATA_W(8), .VEC_LEN(1)) dut1 (
    .clk(clk), .reset(reset), .s(b1.slave), .mac_a(a1), .mac_b(bb1),
    .mac_clr(clr1), .mac_sum(sum1), .busy(busy1)
  );
  mac_unit #(.data_size(8)) mac1 (
    .clk(clk), .reset(clr1), .in_a(a1), .in_b(bb1), .out_sum(sum1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one pair and returns just after the edge that accepted it.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n;
    n = 0;
    b4.s_valid = 1'b1;
    b4.s_a     = a;
    b4.s_b     = b;
`ifdef MAC_FEEDER_LAST_EN
    b4.s_last  = last;
`endif
    while (!b4.s_ready && n < 20) begin
      step();
      n++;
    end
    if (!b4.s_ready) chk("send_timeout", {31'd0, b4.s_ready}, 32'd1);
    step();
    b4.s_valid = 1'b0;
`ifdef MAC_FEEDER_LAST_EN
    b4.s_last  = 1'b0;
`endif
  endtask

  // Called right after the final handshake edge; result must appear two edges later.
  task automatic wait_result(input string tag, input logic [7:0] exp);
    chk({tag, "_valid_k"}, {31'd0, b4.m_valid}, 32'd0);
    step();
    chk({tag, "_valid_k1"}, {31'd0, b4.m_valid}, 32'd0);
    step();
    chk({tag, "_valid_k2"}, {31'd0, b4.m_valid}, 32'd1);
    chk({tag, "_sum"}, {24'd0, b4.m_sum}, {24'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    b4.s_valid = 1'b0; b4.s_a = '0; b4.s_b = '0; b4.m_ready = 1'b1;
    b1.s_valid = 1'b0; b1.s_a = '0; b1.s_b = '0; b1.m_ready = 1'b1;
`ifdef MAC_FEEDER_LAST_EN
    b4.s_last = 1'b0;
    b1.s_last = 1'b0;
`endif

    // Reset state
    step();
    step();
    chk("rst_s_ready", {31'd0, b4.s_ready}, 32'd0);
    chk("rst_mac_clr", {31'd0, clr4}, 32'd1);
    chk("rst_m_valid", {31'd0, b4.m_valid}, 32'd0);
    chk("rst_m_sum", {24'd0, b4.m_sum}, 32'd0);
    chk("rst_mac_a", {24'd0, a4}, 32'd0);
    chk("rst_busy", {31'd0, busy4}, 32'd1);
`ifdef MAC_FEEDER_LAST_EN
    chk("rst_m_len", {29'd0, b4.m_len}, 32'd0);
`endif
    reset = 1'b0;
    step();
    chk("feed_s_ready", {31'd0, b4.s_ready}, 32'd1);
    chk("feed_busy", {31'd0, busy4}, 32'd0);
    chk("feed_mac_sum", {24'd0, sum4}, 32'd0);

    // Continuous stream, m_ready high
    send(8'd1, 8'd2, 1'b0);
    send(8'd3, 8'd4, 1'b0);
    send(8'd5, 8'd6, 1'b0);
    send(8'd7, 8'd8, 1'b0);
    chk("drain_s_ready", {31'd0, b4.s_ready}, 32'd0);
    chk("drain_mac_a", {24'd0, a4}, 32'd7);
    wait_result("v1", 8'd100);
    step();
    chk("v1_valid_1cyc", {31'd0, b4.m_valid}, 32'd0);
    chk("clear_mac_clr", {31'd0, clr4}, 32'd1);
    chk("clear_s_ready", {31'd0, b4.s_ready}, 32'd0);
    step();
    chk("refeed_s_ready", {31'd0, b4.s_ready}, 32'd1);

    // Two-cycle bubble between pairs 2 and 3
    send(8'd1, 8'd2, 1'b0);
    send(8'd3, 8'd4, 1'b0);
    step();
    chk("bubble1_mac_a", {24'd0, a4}, 32'd0);
    chk("bubble1_mac_b", {24'd0, bb4}, 32'd0);
    step();
    chk("bubble2_mac_a", {24'd0, a4}, 32'd0);
    chk("bubble2_mac_b", {24'd0, bb4}, 32'd0);
    send(8'd5, 8'd6, 1'b0);
    send(8'd7, 8'd8, 1'b0);
    wait_result("v2", 8'd100);
    step();
    step();

    // Wraparound, held output, s_valid ignored outside FEED
    b4.m_ready = 1'b0;
    send(8'd16, 8'd16, 1'b0);
    send(8'd1, 8'd1, 1'b0);
    send(8'd0, 8'd0, 1'b0);
    send(8'd0, 8'd0, 1'b0);
    wait_result("wrap", 8'd1);
    b4.s_valid = 1'b1;
    b4.s_a = 8'd99;
    b4.s_b = 8'd99;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("hold%0d_valid", i), {31'd0, b4.m_valid}, 32'd1);
      chk($sformatf("hold%0d_sum", i), {24'd0, b4.m_sum}, 32'd1);
      chk($sformatf("hold%0d_s_ready", i), {31'd0, b4.s_ready}, 32'd0);
      chk($sformatf("hold%0d_mac_a", i), {24'd0, a4}, 32'd0);
    end
    b4.s_valid = 1'b0;
    b4.m_ready = 1'b1;
    step();
    chk("hold_release_valid", {31'd0, b4.m_valid}, 32'd0);
    step();
    for (int i = 0; i < 4; i++) send(8'd2, 8'd2, 1'b0);
    wait_result("after_wrap", 8'd16);
    step();
    step();

    // Reset mid-vector discards partial sum
    send(8'd9, 8'd9, 1'b0);
    send(8'd9, 8'd9, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_mac_clr", {31'd0, clr4}, 32'd1);
    step();
    reset = 1'b0;
    chk("midrst_s_ready", {31'd0, b4.s_ready}, 32'd0);
    chk("midrst_mac_sum", {24'd0, sum4}, 32'd0);
    chk("midrst_m_valid", {31'd0, b4.m_valid}, 32'd0);
    step();
    chk("midrst_refeed", {31'd0, b4.s_ready}, 32'd1);
    for (int i = 0; i < 4; i++) send(8'd1, 8'd1, 1'b0);
    wait_result("after_rst", 8'd4);
    step();
    step();

    // VEC_LEN=1 instance
    chk("len1_s_ready", {31'd0, b1.s_ready}, 32'd1);
    b1.s_valid = 1'b1;
    b1.s_a = 8'd5;
    b1.s_b = 8'd7;
    step();
    chk("len1_drain_s_ready", {31'd0, b1.s_ready}, 32'd0);
    step();
    chk("len1_valid_k1", {31'd0, b1.m_valid}, 32'd0);
    step();
    chk("len1_valid_k2", {31'd0, b1.m_valid}, 32'd1);
    chk("len1_sum", {24'd0, b1.m_sum}, 32'd35);
    step();
    chk("len1_out_done", {31'd0, b1.m_valid}, 32'd0);
    chk("len1_clear_s_ready", {31'd0, b1.s_ready}, 32'd0);
    b1.s_valid = 1'b0;
    step();
    chk("len1_refeed", {31'd0, b1.s_ready}, 32'd1);
    chk("len1_busy", {31'd0, busy1}, 32'd0);

`ifdef MAC_FEEDER_LAST_EN
    // Early termination with s_last, then full-length vector
    send(8'd2, 8'd3, 1'b0);
    send(8'd4, 8'd5, 1'b1);
    wait_result("last", 8'd26);
    chk("last_m_len", {29'd0, b4.m_len}, 32'd2);
    step();
    step();
    for (int i = 0; i < 4; i++) send(8'd1, 8'd1, 1'b0);
    wait_result("full", 8'd4);
    chk("full_m_len", {29'd0, b4.m_len}, 32'd4);
    step();
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
